// File: rtl/func_arbiter_pkg.sv
// func_arbiter_pkg: shared operand width, arbiter state encoding and index-width helper.
package func_arbiter_pkg;
    localparam int W_DEF = 8;

    typedef enum logic [2:0] {IDLE, ISSUE, ARM, RUN, DONE} state_t;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return (r == 0) ? 1 : r;
    endfunction
endpackage

// File: rtl/func_arbiter_rr_picker.sv
// func_arbiter_rr_picker: round-robin pick of the first pending request after the last grant.
module func_arbiter_rr_picker
    import func_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int LW    = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [LW-1:0]    last,
    output logic [LW-1:0]    grant,
    output logic             valid
);
    logic [LW-1:0] idx;

    // Scan farthest candidate first so the nearest one after last wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = LW'((int'(last) + i) % N_REQ);
            if (req[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/func_arbiter.sv
// func_arbiter: round-robin sharing of one multi-cycle func unit among N_REQ requesters,
// latching the winner's operands and sequencing the start/busy handshake.
module func_arbiter
    import func_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N_REQ-1:0]   req_i,
    input  logic [N_REQ*W-1:0] a_i,
    input  logic [N_REQ*W-1:0] b_i,
    output logic [N_REQ-1:0]   ack_o,
    output logic [N_REQ-1:0]   done_o,
    output logic [W-1:0]       y_o,
    output logic               busy_o,
    output logic [W-1:0]       func_a_o,
    output logic [W-1:0]       func_b_o,
    output logic               func_start_o,
    input  logic               func_busy_i,
    input  logic [W-1:0]       func_y_i
);
    localparam int LW = clog2(N_REQ);

    state_t        state;
    logic [LW-1:0] last, g, pick;
    logic          pick_v;
    logic [W-1:0]  a_arr [N_REQ];
    logic [W-1:0]  b_arr [N_REQ];

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign a_arr[k] = a_i[k*W +: W];
        assign b_arr[k] = b_i[k*W +: W];
    end

    func_arbiter_rr_picker #(.N_REQ(N_REQ), .LW(LW)) u_picker (
        .req   (req_i),
        .last  (last),
        .grant (pick),
        .valid (pick_v)
    );

    assign busy_o = (state != IDLE);

    // Operands stay latched after IDLE exit because func samples them live while busy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            last         <= LW'(N_REQ - 1);
            g            <= '0;
            ack_o        <= '0;
            done_o       <= '0;
            y_o          <= '0;
            func_a_o     <= '0;
            func_b_o     <= '0;
            func_start_o <= 1'b0;
        end else begin
            ack_o        <= '0;
            done_o       <= '0;
            func_start_o <= 1'b0;
            case (state)
                IDLE: if (pick_v) begin
                    g            <= pick;
                    func_a_o     <= a_arr[pick];
                    func_b_o     <= b_arr[pick];
                    ack_o        <= N_REQ'(1) << pick;
                    func_start_o <= 1'b1;
                    state        <= ISSUE;
                end
                ISSUE: begin
                    last  <= g;
                    state <= ARM;
                end
                ARM: if (func_busy_i) state <= RUN;
                RUN: if (!func_busy_i) begin
                    y_o    <= func_y_i;
                    done_o <= N_REQ'(1) << g;
                    state  <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_func_arbiter.sv
// tb_func_arbiter: directed scenarios plus randomized client traffic against a
// round-robin / y = a^2 + cbrt(b) scoreboard, with a behavioural stand-in for func.
module tb_func_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0]   req_i, ack_o, done_o;
    logic [N*W-1:0] a_i, b_i;
    logic [W-1:0]   y_o, func_a_o, func_b_o, func_y_i;
    logic           busy_o, func_start_o, func_busy_i;

    logic [W-1:0] a_drv [N];
    logic [W-1:0] b_drv [N];
    logic [N-1:0] req_drv = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_i = req_drv;
        a_i   = '0;
        b_i   = '0;
        for (int k = 0; k < N; k++) begin
            a_i[k*W +: W] = a_drv[k];
            b_i[k*W +: W] = b_drv[k];
        end
    end

    func_arbiter #(.N_REQ(N), .W(W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req_i),
        .a_i          (a_i),
        .b_i          (b_i),
        .ack_o        (ack_o),
        .done_o       (done_o),
        .y_o          (y_o),
        .busy_o       (busy_o),
        .func_a_o     (func_a_o),
        .func_b_o     (func_b_o),
        .func_start_o (func_start_o),
        .func_busy_i  (func_busy_i),
        .func_y_i     (func_y_i)
    );

    function automatic int cbrt(input int b);
        int r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= b) r++;
        return r;
    endfunction

    function automatic int ref_y(input int a, input int b);
        return (a * a + cbrt(b)) % 256;
    endfunction

    function automatic int oh(input logic [N-1:0] v);
        int idx = -1;
        if ($countones(v) != 1) return -1;
        for (int k = 0; k < N; k++) if (v[k]) idx = k;
        return idx;
    endfunction

    function automatic int rr(input logic [N-1:0] r, input int last);
        for (int i = 1; i <= N; i++) if (r[(last + i) % N]) return (last + i) % N;
        return -1;
    endfunction

    // Behavioural func: busy for a random 1..4 cycles after start, result on busy fall.
    int f_cnt, f_T;
    always @(posedge clk or posedge rst) begin : fmodel
        int t;
        if (rst) begin
            func_busy_i <= 1'b0;
            func_y_i    <= '0;
            f_cnt       <= 0;
        end else if (!func_busy_i && func_start_o) begin
            t = $urandom_range(1, 4);
            f_T         <= t;
            f_cnt       <= t;
            func_busy_i <= 1'b1;
        end else if (func_busy_i) begin
            if (f_cnt == 1) begin
                func_busy_i <= 1'b0;
                func_y_i    <= W'(ref_y(int'(func_a_o), int'(func_b_o)));
            end else f_cnt <= f_cnt - 1;
        end
    end

    typedef struct { int k; int y; } job_t;
    job_t sb[$];
    int m_last = N - 1;
    logic [N-1:0] prev_req = '0;
    int ack_n [N];
    int done_n [N];
    int ack_cyc, done_cyc, mk, me;

    // Scoreboard: grant order from the round-robin rule, one job in flight, results per requester.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            m_last = N - 1;
        end else begin
            if (ack_o != '0) begin
                mk = oh(ack_o);
                me = rr(prev_req, m_last);
                checks++;
                if (mk < 0 || mk != me) begin
                    errors++;
                    $display("FAIL ack_grant got=%b want_idx=%0d req=%b", ack_o, me, prev_req);
                end else begin
                    checks++;
                    if (sb.size() != 0 || func_start_o !== 1'b1 || func_a_o !== a_drv[mk] || func_b_o !== b_drv[mk]) begin
                        errors++;
                        $display("FAIL ack_issue inflight=%0d start=%b a=%0d b=%0d want a=%0d b=%0d",
                                 sb.size(), func_start_o, func_a_o, func_b_o, a_drv[mk], b_drv[mk]);
                    end
                    sb.push_back('{mk, ref_y(int'(a_drv[mk]), int'(b_drv[mk]))});
                    m_last = mk;
                    ack_n[mk]++;
                    ack_cyc = cyc;
                end
            end
            if (done_o != '0) begin
                mk = oh(done_o);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected got=%b", done_o);
                end else begin
                    if (mk != sb[0].k || int'(y_o) != sb[0].y) begin
                        errors++;
                        $display("FAIL done_result got done=%b y=%0d want idx=%0d y=%0d", done_o, y_o, sb[0].k, sb[0].y);
                    end
                    void'(sb.pop_front());
                end
                if (mk >= 0) done_n[mk]++;
                done_cyc = cyc;
            end
        end
        prev_req = req_i;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_o == '0 && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (done_o == '0) begin
            errors++;
            $display("FAIL %s done timeout got=%b want=nonzero", tag, done_o);
        end
    endtask

    task automatic wait_ack(input string tag);
        int n = 0;
        while (ack_o == '0 && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (ack_o == '0) begin
            errors++;
            $display("FAIL %s ack timeout got=%b want=nonzero", tag, ack_o);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < N; k++) begin
            a_drv[k] = '0;
            b_drv[k] = '0;
        end
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({ack_o, done_o, y_o, func_a_o, func_b_o, func_start_o, busy_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ack=%b done=%b y=%0d a=%0d b=%0d start=%b busy=%b want all 0",
                     ack_o, done_o, y_o, func_a_o, func_b_o, func_start_o, busy_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic held = 1'b1;
        int n = 0;
        a_drv[0] = 8'd15;
        b_drv[0] = 8'd255;
        req_drv  = 4'b0001;
        tick();
        checks++;
        if (ack_o !== 4'b0001) begin
            errors++;
            $display("FAIL single_ack got=%b want=0001", ack_o);
        end
        req_drv = '0;
        while (done_o == '0 && n < 60) begin
            if (func_a_o !== 8'd15 || func_b_o !== 8'd255) held = 1'b0;
            tick();
            n++;
        end
        checks++;
        if (!held || func_a_o !== 8'd15) begin
            errors++;
            $display("FAIL single_hold got a=%0d want=15", func_a_o);
        end
        checks++;
        if (done_o !== 4'b0001 || y_o !== 8'd231) begin
            errors++;
            $display("FAIL single_done got done=%b y=%0d want 0001 y=231", done_o, y_o);
        end
        checks++;
        if (cyc - ack_cyc != f_T + 2) begin
            errors++;
            $display("FAIL single_latency got=%0d want=%0d", cyc - ack_cyc, f_T + 2);
        end
        tick();
        checks++;
        if (done_o !== '0 || y_o !== 8'd231 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL single_after got done=%b y=%0d busy=%b want 0 231 0", done_o, y_o, busy_o);
        end
    endtask

    task automatic test_pair();
        int d;
        a_drv[1] = 8'd0;
        b_drv[1] = 8'd1;
        a_drv[3] = 8'd8;
        b_drv[3] = 8'd64;
        req_drv  = 4'b1010;
        tick();
        checks++;
        if (ack_o !== 4'b0010) begin
            errors++;
            $display("FAIL pair_first_ack got=%b want=0010", ack_o);
        end
        req_drv = 4'b1000;
        wait_done("pair_first");
        checks++;
        if (done_o !== 4'b0010 || y_o !== 8'd1) begin
            errors++;
            $display("FAIL pair_first_done got done=%b y=%0d want 0010 y=1", done_o, y_o);
        end
        d = cyc;
        tick();
        wait_ack("pair_second");
        checks++;
        if (ack_o !== 4'b1000 || cyc != d + 2) begin
            errors++;
            $display("FAIL pair_second_ack got=%b gap=%0d want 1000 gap=2", ack_o, cyc - d);
        end
        req_drv = '0;
        tick();
        wait_done("pair_second");
        checks++;
        if (done_o !== 4'b1000 || y_o !== 8'd68) begin
            errors++;
            $display("FAIL pair_second_done got done=%b y=%0d want 1000 y=68", done_o, y_o);
        end
        tick();
    endtask

    task automatic test_all_rr();
        for (int k = 0; k < N; k++) begin
            a_drv[k] = W'($urandom);
            b_drv[k] = W'($urandom);
        end
        req_drv = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_ack("rr");
            checks++;
            if (ack_o !== 4'(1 << (i % N))) begin
                errors++;
                $display("FAIL rr_order step=%0d got=%b want_idx=%0d", i, ack_o, i % N);
            end
            if (i == 4) req_drv = '0;
            tick();
        end
        wait_done("rr_last");
        checks++;
        if (done_o !== 4'b0001) begin
            errors++;
            $display("FAIL rr_last_done got=%b want=0001", done_o);
        end
        repeat (3) tick();
    endtask

    task automatic test_withdraw();
        int a2, d2;
        a2 = ack_n[2];
        d2 = done_n[2];
        a_drv[0] = W'($urandom);
        b_drv[0] = W'($urandom);
        a_drv[2] = W'($urandom);
        req_drv  = 4'b0001;
        tick();
        req_drv = '0;
        tick();
        req_drv[2] = 1'b1;
        tick();
        req_drv[2] = 1'b0;
        wait_done("withdraw");
        checks++;
        if (done_o !== 4'b0001) begin
            errors++;
            $display("FAIL withdraw_done got=%b want=0001", done_o);
        end
        repeat (10) tick();
        checks++;
        if (ack_n[2] != a2 || done_n[2] != d2) begin
            errors++;
            $display("FAIL withdraw_req2 got acks=%0d dones=%0d want %0d %0d", ack_n[2], done_n[2], a2, d2);
        end
    endtask

    task automatic test_reset_midrun();
        int dt = 0;
        for (int k = 0; k < N; k++) dt += done_n[k];
        a_drv[0] = 8'd9;
        b_drv[0] = 8'd100;
        req_drv  = 4'b0001;
        tick();
        req_drv = '0;
        tick();
        tick();
        checks++;
        if (busy_o !== 1'b1 || func_busy_i !== 1'b1) begin
            errors++;
            $display("FAIL midrun_busy got busy=%b fbusy=%b want 1 1", busy_o, func_busy_i);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ack_o, done_o, y_o, func_a_o, func_b_o, func_start_o, busy_o} !== '0) begin
            errors++;
            $display("FAIL midrun_async got ack=%b done=%b y=%0d a=%0d start=%b busy=%b want all 0",
                     ack_o, done_o, y_o, func_a_o, func_start_o, busy_o);
        end
        tick();
        rst = 1'b0;
        repeat (8) tick();
        for (int k = 0; k < N; k++) dt -= done_n[k];
        checks++;
        if (dt != 0) begin
            errors++;
            $display("FAIL midrun_no_done got=%0d extra dones want=0", -dt);
        end
        a_drv[0] = 8'd8;
        b_drv[0] = 8'd64;
        a_drv[1] = 8'd3;
        b_drv[1] = 8'd27;
        req_drv  = 4'b0011;
        tick();
        checks++;
        if (ack_o !== 4'b0001) begin
            errors++;
            $display("FAIL midrun_priority got=%b want=0001", ack_o);
        end
        req_drv = 4'b0010;
        wait_done("midrun_r0");
        checks++;
        if (done_o !== 4'b0001 || y_o !== 8'd68) begin
            errors++;
            $display("FAIL midrun_r0 got done=%b y=%0d want 0001 y=68", done_o, y_o);
        end
        tick();
        wait_ack("midrun_r1");
        req_drv = '0;
        tick();
        wait_done("midrun_r1");
        checks++;
        if (done_o !== 4'b0010 || y_o !== 8'd12) begin
            errors++;
            $display("FAIL midrun_r1 got done=%b y=%0d want 0010 y=12", done_o, y_o);
        end
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] waiting = '0;
        int a0 = 0, d0 = 0, a1 = 0, d1 = 0, n = 0;
        for (int k = 0; k < N; k++) begin
            a0 += ack_n[k];
            d0 += done_n[k];
        end
        while (n < 900 && (n < 500 || req_drv != '0 || waiting != '0)) begin
            for (int k = 0; k < N; k++) begin
                if (ack_o[k]) begin
                    req_drv[k] = 1'b0;
                    waiting[k] = 1'b1;
                end else if (req_drv[k] && $urandom_range(0, 49) == 0) begin
                    req_drv[k] = 1'b0;
                end
                if (done_o[k]) waiting[k] = 1'b0;
                if (n < 500 && !req_drv[k] && !waiting[k] && $urandom_range(0, 3) == 0) begin
                    a_drv[k]   = W'($urandom);
                    b_drv[k]   = W'($urandom);
                    req_drv[k] = 1'b1;
                end
            end
            tick();
            n++;
        end
        repeat (3) tick();
        for (int k = 0; k < N; k++) begin
            a1 += ack_n[k];
            d1 += done_n[k];
        end
        checks++;
        if (a1 - a0 != d1 - d0 || a1 == a0 || sb.size() != 0) begin
            errors++;
            $display("FAIL random_balance got acks=%0d dones=%0d pending=%0d want equal nonzero 0",
                     a1 - a0, d1 - d0, sb.size());
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            ack_n[k]  = 0;
            done_n[k] = 0;
        end
        test_reset();
        test_single();
        test_pair();
        test_all_rr();
        test_withdraw();
        test_reset_midrun();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
